ifu_prefetch: RTL and testbench



---
 rtl/ifu_prefetch.sv | 133 +++++++++++++
 tb/tb_ifu_prefetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Decoupled instruction prefetcher. Issues credit-limited word
//               fetches, buffers in-order responses in a FIFO, and handles
//               redirect flushes by dropping responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   input  logic              mem_rsp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_err
);

   localparam int unsigned        c_CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned        c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_CNT_W:0]   c_DEPTH_X = (c_CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  r_rsp_pc;
   logic [c_CNT_W-1:0] r_inflight;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] r_drop;
   logic               r_halt;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [INST_W-1:0]  r_data [DEPTH];
   logic [ADDR_W-1:0]  r_pc   [DEPTH];
   logic [DEPTH-1:0]   r_err;

   logic [c_CNT_W:0]   w_occupancy;
   logic               w_req_fire;
   logic               w_rsp_keep;
   logic               w_deq;
   logic [c_CNT_W-1:0] w_inflight_nxt;
   logic [ADDR_W-1:0]  w_redirect_pc;
   logic               w_unused;

   assign w_unused       = ^redirect_pc[1:0];
   assign w_redirect_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count};

   // Requests already in flight hold a FIFO slot, so the FIFO can never overflow.
   assign mem_req_valid  = rst_n && !r_halt && !redirect_valid && (w_occupancy < c_DEPTH_X);
   assign mem_req_addr   = r_fetch_pc;
   assign w_req_fire     = mem_req_valid && mem_req_ready;
   assign w_rsp_keep     = mem_rsp_valid && (r_drop == '0) && !redirect_valid;
   assign w_deq          = inst_valid && inst_ready;
   assign w_inflight_nxt = r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(mem_rsp_valid);

   assign inst_valid = (r_count != '0);
   assign inst_data  = r_data[r_rd_ptr];
   assign inst_pc    = r_pc[r_rd_ptr];
   assign inst_err   = r_err[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_inflight <= '0;
         r_count    <= '0;
         r_drop     <= '0;
         r_halt     <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_count    <= '0;
            r_drop     <= w_inflight_nxt;
            r_halt     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (mem_rsp_valid && (r_drop != '0)) begin
               r_drop <= r_drop - c_CNT_W'(1);
            end
            if (w_rsp_keep) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
               r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
               if (mem_rsp_err) begin
                  r_halt <= 1'b1;
               end
            end
            if (w_deq) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_rsp_keep) - c_CNT_W'(w_deq);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_data[i] <= '0;
            r_pc[i]   <= '0;
         end
         r_err <= '0;
      end else if (w_rsp_keep) begin
         r_data[r_wr_ptr] <= mem_rsp_data;
         r_pc[r_wr_ptr]   <= r_rsp_pc;
         r_err[r_wr_ptr]  <= mem_rsp_err;
      end
   end

   a_occupancy : assert property (@(posedge clk) disable iff (!rst_n) w_occupancy <= c_DEPTH_X);

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Self-checking bench for ifu_prefetch with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        mem_rsp_err = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_err;

   ifu_prefetch #(
      .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_err(inst_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; logic err; } ent_t;
   typedef struct { bit rst; bit rdy; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc; } vec_t;

   // Reference model: outstanding requests in issue order, and the visible instruction queue.
   pend_t       pend[$];
   ent_t        fifo[$];
   logic [31:0] m_fetch_pc;
   bit          m_halt;
   int          cyc;
   int          lat = 1;
   logic [31:0] err_addr = 32'h1;
   bit          rand_err_en = 1'b0;

   bit          d_redir, d_rdy, d_inrdy, d_rv, d_iv, d_rsp, d_err;
   logic [31:0] d_rpc, d_data;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
      d_redir = redir; d_rpc = rpc; d_rdy = rq_rdy; d_inrdy = in_rdy;
      redirect_valid = redir; redirect_pc = rpc; mem_req_ready = rq_rdy; inst_ready = in_rdy;
      d_rsp = (pend.size() > 0) && (pend.size() > 0 ? pend[0].due <= cyc : 1'b0);
      d_data = d_rsp ? data_of(pend[0].addr) : '0;
      d_err  = d_rsp && ((pend[0].addr == err_addr) || (rand_err_en && $urandom_range(0, 15) == 0));
      mem_rsp_valid = d_rsp; mem_rsp_data = d_data; mem_rsp_err = d_err;
      d_rv = !m_halt && !redir && ((pend.size() + fifo.size()) < DEPTH);
      d_iv = fifo.size() != 0;
      #1;
      chk("req_valid", mem_req_valid, d_rv);
      chk("req_addr", mem_req_addr, m_fetch_pc);
      chk("inst_valid", inst_valid, d_iv);
      if (d_iv) begin
         chk("inst_data", inst_data, fifo[0].data);
         chk("inst_pc", inst_pc, fifo[0].pc);
         chk("inst_err", inst_err, fifo[0].err);
      end
   endtask

   task automatic advance();
      pend_t p;
      @(posedge clk);
      if (d_iv && d_inrdy) void'(fifo.pop_front());
      if (d_rsp) begin
         p = pend.pop_front();
         if (!p.stale && !d_redir) begin
            fifo.push_back('{data: d_data, pc: p.addr, err: d_err});
            if (d_err) m_halt = 1'b1;
         end
      end
      if (d_rv && d_rdy) begin
         pend.push_back('{addr: m_fetch_pc, due: cyc + lat, stale: 1'b0});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (d_redir) begin
         fifo.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_fetch_pc = {d_rpc[31:2], 2'b00};
         m_halt = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
      drive(redir, rpc, rq_rdy, in_rdy);
      advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      redirect_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; inst_ready = 1'b0;
      #1;
      chk("rst_req_valid", mem_req_valid, 1'b0);
      chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_err", inst_err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pend.delete(); fifo.delete();
      m_fetch_pc = 32'h8000_0000; m_halt = 1'b0; cyc = 1;
   endtask

   task automatic wait_first_inst(input string name, input logic [31:0] exp_pc, input logic exp_err);
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (fifo.size() > 0) begin
            chk({name, "_pc"}, inst_pc, exp_pc);
            chk({name, "_err"}, inst_err, exp_err);
            advance();
            return;
         end
         advance();
      end
      checks++; errors++;
      $display("FAIL %s: timeout waiting for inst_valid, got none expected pc %h", name, exp_pc);
   endtask

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1, 1, 1, 32'h8000_0000, 0, 32'h0};
      tbl[1]  = '{0, 1, 1, 32'h8000_0004, 0, 32'h0};
      tbl[2]  = '{0, 1, 1, 32'h8000_0008, 1, 32'h8000_0000};
      tbl[3]  = '{0, 1, 1, 32'h8000_000C, 1, 32'h8000_0004};
      tbl[4]  = '{0, 1, 1, 32'h8000_0010, 1, 32'h8000_0008};
      tbl[5]  = '{1, 0, 1, 32'h8000_0000, 0, 32'h0};
      tbl[6]  = '{0, 0, 1, 32'h8000_0004, 0, 32'h0};
      tbl[7]  = '{0, 0, 1, 32'h8000_0008, 1, 32'h8000_0000};
      tbl[8]  = '{0, 0, 1, 32'h8000_000C, 1, 32'h8000_0000};
      tbl[9]  = '{0, 0, 0, 32'h8000_0010, 1, 32'h8000_0000};
      tbl[10] = '{0, 0, 0, 32'h8000_0010, 1, 32'h8000_0000};
      tbl[11] = '{0, 1, 0, 32'h8000_0010, 1, 32'h8000_0000};
      tbl[12] = '{0, 1, 1, 32'h8000_0010, 1, 32'h8000_0004};
      tbl[13] = '{0, 1, 1, 32'h8000_0014, 1, 32'h8000_0008};
      tbl[14] = '{0, 1, 1, 32'h8000_0018, 1, 32'h8000_000C};
      tbl[15] = '{0, 1, 1, 32'h8000_001C, 1, 32'h8000_0010};

      m_fetch_pc = 32'h8000_0000; m_halt = 1'b0; cyc = 1;

      // Streaming from reset, then credit stall and drain with a 1-cycle memory.
      lat = 1;
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].rst) do_reset();
         drive(1'b0, 32'h0, 1'b1, tbl[i].rdy);
         chk($sformatf("tbl%0d_req_valid", i), mem_req_valid, tbl[i].rv);
         chk($sformatf("tbl%0d_req_addr", i), mem_req_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].iv);
         if (tbl[i].iv) chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].pc);
         advance();
      end

      // Redirect with two requests outstanding on a 3-cycle memory.
      do_reset();
      lat = 3;
      step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      drive(1'b1, 32'h8000_0103, 1'b1, 1'b1);
      chk("redir_req_forced_low", mem_req_valid, 1'b0);
      advance();
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("redir_next_addr", mem_req_addr, 32'h8000_0100);
      advance();
      wait_first_inst("redir_first", 32'h8000_0100, 1'b0);

      // Redirect coinciding with a response and a would-be request.
      do_reset();
      lat = 1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 32'h8000_0200, 1'b1, 1'b0);
      chk("redir_rsp_present", mem_rsp_valid, 1'b1);
      chk("redir_same_req_low", mem_req_valid, 1'b0);
      advance();
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("redir_fifo_empty", inst_valid, 1'b0);
      advance();
      wait_first_inst("redir2_first", 32'h8000_0200, 1'b0);

      // Fetch fault halts requests until redirect.
      do_reset();
      err_addr = 32'h8000_0008;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("err_head_pc", inst_pc, 32'h8000_0008);
      chk("err_head_flag", inst_err, 1'b1);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         chk("halt_no_req", mem_req_valid, 1'b0);
         advance();
      end
      step(1'b1, 32'h0, 1'b1, 1'b1);
      err_addr = 32'h1;
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("err_resume_valid", mem_req_valid, 1'b1);
      chk("err_resume_addr", mem_req_addr, 32'h0);
      advance();
      wait_first_inst("err_resume", 32'h0, 1'b0);

      // Address wrap at the top of the address space.
      step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("wrap_addr0", mem_req_addr, 32'hFFFF_FFFC);
      advance();
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("wrap_addr1", mem_req_addr, 32'h0000_0000);
      advance();
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

      // Randomized traffic with a mid-run reset.
      rand_err_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         lat = $urandom_range(1, 4);
         step($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
